// File: rtl/vj_window_scanner.sv
// Viola-Jones window scanner: raster-walks WINxWIN windows over one frame,
// drives the cascade one window at a time and queues passes. Option: VJ_SCAN_BACKPRESSURE_EN.
module vj_window_scanner #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int WIN        = 19,
  parameter int STEP_X     = 1,
  parameter int STEP_Y     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        eval_start,
  output logic [9:0]  eval_win_x,
  output logic [8:0]  eval_win_y,
  input  logic        eval_done,
  input  logic        eval_pass,
  input  logic [31:0] eval_score,
  output logic        det_valid,
  input  logic        det_ready,
  output logic [9:0]  det_x,
  output logic [8:0]  det_y,
  output logic [31:0] det_score,
  output logic [15:0] det_count,
  output logic [7:0]  drop_count
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ADVANCE, DONE
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 51;
  localparam logic [10:0] X_MAX = 11'(IMG_W - WIN);
  localparam logic [10:0] Y_MAX = 11'(IMG_H - WIN);

  state_t      state, state_n;
  logic [9:0]  x, x_n;
  logic [8:0]  y, y_n;
  logic        start_n;
  logic [10:0] x_nx, y_nx;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [EW-1:0] head;
  logic empty, full, pop;
  logic want_push, push, drop;
  logic stall, clear;

  assign x_nx = {1'b0, x} + 11'(STEP_X);
  assign y_nx = {2'b0, y} + 11'(STEP_Y);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && det_ready;

  assign want_push = (state == WAIT) && eval_done && eval_pass;
  assign push      = want_push && (!full || pop);
  assign drop      = want_push && !push;
  assign clear     = (state == IDLE) && frame_start;

`ifdef VJ_SCAN_BACKPRESSURE_EN
  assign stall = full && !pop;
`else
  assign stall = 1'b0;
`endif

  // Next-state and scan-position logic
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    start_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          x_n     = '0;
          y_n     = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          start_n = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (eval_done) state_n = ADVANCE;
      end
      ADVANCE: begin
        if (x_nx <= X_MAX) begin
          x_n     = x_nx[9:0];
          state_n = ISSUE;
        end else begin
          x_n = '0;
          if (y_nx <= Y_MAX) begin
            y_n     = y_nx[8:0];
            state_n = ISSUE;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, window position and start pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      eval_start <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      eval_start <= start_n;
    end
  end

  // Per-frame pass and drop counters, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_count  <= '0;
      drop_count <= '0;
    end else if (clear) begin
      det_count  <= '0;
      drop_count <= '0;
    end else begin
      if (want_push && det_count != 16'hFFFF)
        det_count <= det_count + 16'd1;
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  // Detection FIFO pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Detection FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {x, y, eval_score};
  end

  assign head       = mem[rptr[AW-1:0]];
  assign det_valid  = !empty;
  assign det_x      = det_valid ? head[50:41] : '0;
  assign det_y      = det_valid ? head[40:32] : '0;
  assign det_score  = det_valid ? head[31:0]  : '0;

  assign eval_win_x = x;
  assign eval_win_y = y;
  assign frame_busy = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_vj_window_scanner.sv
// Scoreboard bench for vj_window_scanner on a 24x21 image, stride 2,
// 4-entry FIFO; expectations follow VJ_SCAN_BACKPRESSURE_EN.
module tb_vj_window_scanner;

  localparam int IW = 24;
  localparam int IH = 21;
  localparam int WN = 19;
  localparam int ST = 2;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        frame_busy, frame_done;
  logic        eval_start;
  logic [9:0]  eval_win_x;
  logic [8:0]  eval_win_y;
  logic        eval_done, eval_pass;
  logic [31:0] eval_score;
  logic        det_valid, det_ready;
  logic [9:0]  det_x;
  logic [8:0]  det_y;
  logic [31:0] det_score;
  logic [15:0] det_count;
  logic [7:0]  drop_count;

  vj_window_scanner #(
    .IMG_W(IW), .IMG_H(IH), .WIN(WN),
    .STEP_X(ST), .STEP_Y(ST), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .eval_start(eval_start),
    .eval_win_x(eval_win_x), .eval_win_y(eval_win_y),
    .eval_done(eval_done), .eval_pass(eval_pass),
    .eval_score(eval_score),
    .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_score(det_score),
    .det_count(det_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int lat = 2;
  int n_eval = 0;
  int n_done = 0;
  bit valid_seen = 0;
  logic [18:0] exp_win[$];
  logic [50:0] exp_det[$];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic pass_of(input logic [9:0] px,
                                   input logic [8:0] py);
    case (mode)
      1:       return (px == 10'd2 && py == 9'd2);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] score_of(input logic [9:0] px,
                                           input logic [8:0] py);
    if (mode == 1) return 32'h0000_0123;
    return 32'h8000_0000 | (32'(px) << 8) | 32'(py);
  endfunction

  // Cascade model and window-order monitor
  initial begin
    logic [9:0] cx;
    logic [8:0] cy;
    eval_done  = 1'b0;
    eval_pass  = 1'b0;
    eval_score = '0;
    forever begin
      @(posedge clk); #1;
      if (eval_start) begin
        n_eval++;
        if (exp_win.size() == 0)
          check("eval_unexpected", 64'(eval_start), 64'd0);
        else
          check("win_order", {eval_win_x, eval_win_y},
                exp_win.pop_front());
        cx = eval_win_x;
        cy = eval_win_y;
        repeat (lat - 1) begin @(posedge clk); #1; end
        if (frame_busy)
          check("win_hold", {eval_win_x, eval_win_y}, {cx, cy});
        eval_done  = 1'b1;
        eval_pass  = pass_of(cx, cy);
        eval_score = score_of(cx, cy);
        @(posedge clk); #1;
        eval_done  = 1'b0;
        eval_pass  = 1'b0;
        eval_score = '0;
      end
    end
  end

  // Detection pop monitor
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (det_valid) begin
        valid_seen = 1'b1;
        if (det_ready) begin
          if (exp_det.size() == 0)
            check("det_unexpected", 64'(det_valid), 64'd0);
          else
            check("det_entry", {det_x, det_y, det_score},
                  exp_det.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic push_wins();
    for (int yy = 0; yy <= IH - WN; yy += ST)
      for (int xx = 0; xx <= IW - WN; xx += ST)
        exp_win.push_back({10'(xx), 9'(yy)});
  endtask

  task automatic wait_done(input int budget, input int base,
                           output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (n_done > base) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int base, base_ev;
    bit seen;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    det_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs",
          {frame_busy, frame_done, eval_start, det_valid,
           eval_win_x, eval_win_y, det_x, det_y, det_score,
           det_count, drop_count}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: all windows fail
    mode = 0; lat = 2; det_ready = 1'b1; valid_seen = 1'b0;
    base = n_done;
    push_wins();
    pulse_start();
    check("t1_busy", 64'(frame_busy), 64'd1);
    @(posedge clk); #1;
    check("t1_first_start", 64'(eval_start), 64'd1);
    wait_done(200, base, seen);
    check("t1_done_seen", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_cnt", 64'(n_done - base), 64'd1);
    check("t1_det_count", 64'(det_count), 64'd0);
    check("t1_valid_seen", 64'(valid_seen), 64'd0);
    check("t1_wins_left", 64'(exp_win.size()), 64'd0);
    check("t1_busy_end", 64'(frame_busy), 64'd0);

    // 2: only (2,2) passes
    mode = 1;
    base = n_done;
    exp_det.push_back({10'd2, 9'd2, 32'h0000_0123});
    push_wins();
    pulse_start();
    wait_done(200, base, seen);
    check("t2_done_seen", 64'(seen), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t2_det_count", 64'(det_count), 64'd1);
    check("t2_drop_count", 64'(drop_count), 64'd0);
    check("t2_det_left", 64'(exp_det.size()), 64'd0);
    check("t2_valid_end", 64'(det_valid), 64'd0);

    // 3/4: all pass into a blocked FIFO
    mode = 2; det_ready = 1'b0;
    base = n_done; base_ev = n_eval;
    push_wins();
    exp_det.push_back({10'd0, 9'd0, 32'h8000_0000});
    exp_det.push_back({10'd2, 9'd0, 32'h8000_0200});
    exp_det.push_back({10'd4, 9'd0, 32'h8000_0400});
    exp_det.push_back({10'd0, 9'd2, 32'h8000_0002});
`ifdef VJ_SCAN_BACKPRESSURE_EN
    exp_det.push_back({10'd2, 9'd2, 32'h8000_0202});
    exp_det.push_back({10'd4, 9'd2, 32'h8000_0402});
`endif
    pulse_start();
    wait_done(300, base, seen);
    check("t3_valid_full", 64'(det_valid), 64'd1);
`ifdef VJ_SCAN_BACKPRESSURE_EN
    check("t4_stalled", 64'(seen), 64'd0);
    check("t4_stall_evals", 64'(n_eval - base_ev), 64'd4);
    check("t4_busy", 64'(frame_busy), 64'd1);
    det_ready = 1'b1;
    wait_done(300, base, seen);
    check("t4_done_seen", 64'(seen), 64'd1);
`else
    check("t3_done_seen", 64'(seen), 64'd1);
    check("t3_drop_mid", 64'(drop_count), 64'd2);
    det_ready = 1'b1;
`endif
    repeat (10) @(posedge clk);
    #1;
    check("t3_det_count", 64'(det_count), 64'd6);
`ifdef VJ_SCAN_BACKPRESSURE_EN
    check("t3_drop_count", 64'(drop_count), 64'd0);
`else
    check("t3_drop_count", 64'(drop_count), 64'd2);
`endif
    check("t3_det_left", 64'(exp_det.size()), 64'd0);
    check("t3_valid_end", 64'(det_valid), 64'd0);

    // 5: re-pulse ignored, reset during WAIT
    mode = 2; lat = 3; det_ready = 1'b0;
    base = n_done; base_ev = n_eval;
    push_wins();
    exp_det.push_back({10'd0, 9'd0, 32'h8000_0000});
    exp_det.push_back({10'd2, 9'd0, 32'h8000_0200});
    pulse_start();
    for (int i = 0; i < 200 && n_eval - base_ev < 2; i++) begin
      @(posedge clk); #2;
    end
    pulse_start();
    for (int i = 0; i < 200 && n_eval - base_ev < 3; i++) begin
      @(posedge clk); #2;
    end
    check("t5_evals_before", 64'(n_eval - base_ev), 64'd3);
    check("t5_valid_pre", 64'(det_valid), 64'd1);
    reset_n = 1'b0;
    #2;
    check("t5_rst_busy", 64'(frame_busy), 64'd0);
    check("t5_rst_valid", 64'(det_valid), 64'd0);
    check("t5_rst_count", 64'(det_count), 64'd0);
    reset_n = 1'b1;
    exp_win.delete();
    exp_det.delete();
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done", 64'(n_done - base), 64'd0);
    check("t5_idle_evals", 64'(n_eval - base_ev), 64'd3);

    mode = 0; det_ready = 1'b1;
    base = n_done;
    push_wins();
    pulse_start();
    wait_done(300, base, seen);
    check("t5_done_seen", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_wins_left", 64'(exp_win.size()), 64'd0);
    check("t5_done_cnt", 64'(n_done - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
